flit_mux_rr: RTL and testbench

//  Parametrised N:1 flit multiplexer for the NoC router output stage: generalises the 2:1 mux to NPORT inputs.

---
 rtl/flit_mux_rr.sv | 147 ++++++++++++++
 tb/tb_flit_mux_rr.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_mux_rr.sv
// N:1 NoC output-stage flit multiplexer with a registered valid/ready output,
// round-robin arbitration with wormhole packet locking, and a static-select mode.
module flit_mux_rr #(
    parameter int NPORT = 4,
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int PORTW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT*VCHW-1:0]  ivch,
    output logic [NPORT-1:0]       iready,
    input  logic                   mode,
    input  logic [PORTW-1:0]       sel,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic                   oready,
    output logic                   locked,
    output logic [PORTW-1:0]       gnt
);

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e           state_q, state_d;
    logic [PORTW-1:0] gnt_q, gnt_d;
    logic [PORTW-1:0] ptr_q, ptr_d;
    logic [DATAW-1:0] odata_q, odata_d;
    logic [VCHW-1:0]  ovch_q, ovch_d;
    logic             ovalid_q, ovalid_d;

    logic             ld;
    logic             acc;
    logic [NPORT-1:0] head_req;
    logic [NPORT-1:0] cand;
    logic             win_found;
    logic [PORTW-1:0] win_idx;
    logic [PORTW-1:0] src_idx;
    logic [DATAW-1:0] src_flit;
    logic [VCHW-1:0]  src_vch;
    int               k;

    assign ld = !ovalid_q || oready;

    always_comb begin
        head_req = '0;
        for (int p = 0; p < NPORT; p++) begin
            head_req[p] = ivalid[p] && (idata[p*DATAW+DATAW-2 +: 2] == T_HEAD);
        end
    end

    // First HEAD requester at or after the pointer, wrapping at NPORT-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int i = 0; i < NPORT; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NPORT) k = k - NPORT;
            if (!win_found && head_req[k]) begin
                win_found = 1'b1;
                win_idx   = PORTW'(k);
            end
        end
    end

    // A held lock overrides mode until the tail has gone through.
    always_comb begin
        cand    = '0;
        src_idx = gnt_q;
        if (state_q == LOCK) begin
            cand[gnt_q] = 1'b1;
        end else if (mode) begin
            cand[win_idx] = win_found;
            src_idx       = win_idx;
        end else begin
            src_idx = sel;
            if (int'(sel) < NPORT) cand[sel] = 1'b1;
        end
    end

    assign iready   = (rst || !ld) ? '0 : cand;
    assign acc      = |(ivalid & iready);
    assign src_flit = idata[src_idx*DATAW +: DATAW];
    assign src_vch  = ivch[src_idx*VCHW +: VCHW];

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        odata_d  = odata_q;
        ovch_d   = ovch_q;
        ovalid_d = ovalid_q;
        if (ld) begin
            ovalid_d = acc;
            if (acc) begin
                odata_d = src_flit;
                ovch_d  = src_vch;
            end
        end
        case (state_q)
            IDLE: begin
                if (acc) begin
                    gnt_d = src_idx;
                    if (mode) state_d = LOCK;
                end
            end
            LOCK: begin
                if (acc && src_flit[DATAW-1 -: 2] == T_TAIL) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == PORTW'(NPORT-1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            odata_q  <= '0;
            ovch_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            odata_q  <= odata_d;
            ovch_q   <= ovch_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign odata  = odata_q;
    assign ovch   = ovch_q;
    assign ovalid = ovalid_q;
    assign locked = (state_q == LOCK);
    assign gnt    = gnt_q;

endmodule

// File: tb/tb_flit_mux_rr.sv
// Randomized and directed bench for flit_mux_rr against a packet-level
// reference model; a second 3-port instance covers non-power-of-two wrap.
module tb_flit_mux_rr;

    localparam int N  = 4;
    localparam int DW = 66;
    localparam int VW = 2;
    localparam int PW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N*DW-1:0] idata;
    logic [N-1:0]    ivalid;
    logic [N*VW-1:0] ivch;
    logic [N-1:0]    iready;
    logic            mode;
    logic [PW-1:0]   sel;
    logic [DW-1:0]   odata;
    logic            ovalid;
    logic [VW-1:0]   ovch;
    logic            oready;
    logic            locked;
    logic [PW-1:0]   gnt;

    logic [3*DW-1:0] idata3;
    logic [2:0]      ivalid3;
    logic [3*VW-1:0] ivch3;
    logic [2:0]      iready3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [DW-1:0]   odata3;
    logic            ovalid3;
    logic [VW-1:0]   ovch3;
    logic            oready3;
    logic            locked3;
    logic [1:0]      gnt3;

    flit_mux_rr #(.NPORT(N), .DATAW(DW), .VCHW(VW), .PORTW(PW)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .iready(iready), .mode(mode), .sel(sel), .odata(odata),
        .ovalid(ovalid), .ovch(ovch), .oready(oready), .locked(locked),
        .gnt(gnt)
    );

    flit_mux_rr #(.NPORT(3), .DATAW(DW), .VCHW(VW), .PORTW(2)) dut3 (
        .clk(clk), .rst(rst), .idata(idata3), .ivalid(ivalid3), .ivch(ivch3),
        .iready(iready3), .mode(mode3), .sel(sel3), .odata(odata3),
        .ovalid(ovalid3), .ovch(ovch3), .oready(oready3), .locked(locked3),
        .gnt(gnt3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Sources: each port emits packets HEAD, DATA..., TAIL
    int s_idx[N], s_len[N], s_pkt[N], s_left[N], s_stall[N];
    int s_lmin[N], s_lmax[N];
    int vprob;
    bit restart_en;

    // Reference model state
    bit            m_lock, m_ov;
    int            m_gnt, m_ptr;
    logic [DW-1:0] m_od;
    logic [VW-1:0] m_ovch;

    logic [DW-1:0] sbq[$];
    int            deliv[N];
    int            head_order[$];
    int            cur_port;
    bit            ilv_chk;
    logic [N-1:0]  dut_acc;

    function automatic logic [DW-1:0] mkflit(int p, int pkt, int idx, int len);
        logic [1:0] t;
        t = (idx == 0) ? 2'b01 : (idx == len - 1) ? 2'b11 : 2'b10;
        return {t, 8'(p), 16'(pkt), 8'(idx), 32'hA500_0000 ^ 32'(pkt*977 + p*31 + idx)};
    endfunction

    task automatic src_set(int p, int left, int lmin, int lmax);
        s_left[p]  = left;
        s_lmin[p]  = lmin;
        s_lmax[p]  = lmax;
        s_idx[p]   = 0;
        s_pkt[p]   = s_pkt[p] + 1;
        s_stall[p] = 0;
        s_len[p]   = int'($urandom_range(lmax, lmin));
    endtask

    task automatic src_off_all();
        for (int p = 0; p < N; p++) s_left[p] = 0;
    endtask

    task automatic cycle();
        logic [N-1:0]  er;
        logic [DW-1:0] fa, od_s;
        logic [VW-1:0] va;
        int            ap, q, port;
        bit            ld, hs;
        for (int p = 0; p < N; p++) begin
            ivalid[p] = (s_left[p] > 0) && ($urandom_range(99) < vprob);
            idata[p*DW +: DW] = mkflit(p, s_pkt[p], s_idx[p], s_len[p]);
            ivch[p*VW +: VW] = VW'(s_pkt[p] + p);
        end
        #1;
        ld = !m_ov || oready;
        er = '0;
        if (!rst && ld) begin
            if (m_lock) er[m_gnt] = 1'b1;
            else if (!mode) begin
                if (int'(sel) < N) er[sel] = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    q = (m_ptr + i) % N;
                    if (ivalid[q] && idata[q*DW+DW-2 +: 2] == 2'b01) begin
                        er[q] = 1'b1;
                        break;
                    end
                end
            end
        end
        ap = -1;
        for (int p = 0; p < N; p++) if (er[p] && ivalid[p]) ap = p;
        if (ap >= 0) begin
            fa = idata[ap*DW +: DW];
            va = ivch[ap*VW +: VW];
        end
        check("iready", iready, er);
        check("ovalid", ovalid, m_ov);
        check("locked", locked, m_lock);
        check("gnt", gnt, m_gnt);
        if (m_ov) begin
            check("odata", odata, m_od);
            check("ovch", ovch, m_ovch);
        end
        dut_acc = ivalid & iready;
        hs = ovalid && oready;
        od_s = odata;
        @(posedge clk);
        if (hs) begin
            check("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                check("sb_data", od_s, sbq.pop_front());
                port = int'(od_s[DW-3 -: 8]);
                if (port < N) deliv[port]++;
                if (od_s[DW-1 -: 2] == 2'b01) begin
                    head_order.push_back(port);
                    cur_port = port;
                end else if (ilv_chk) begin
                    check("interleave", port, cur_port);
                end
            end
        end
        if (rst) begin
            m_lock = 0; m_ov = 0; m_gnt = 0; m_ptr = 0; m_od = '0; m_ovch = '0;
            sbq.delete();
        end else begin
            if (ld) begin
                m_ov = (ap >= 0);
                if (ap >= 0) begin
                    m_od = fa;
                    m_ovch = va;
                    sbq.push_back(fa);
                end
            end
            if (ap >= 0) begin
                if (m_lock) begin
                    if (fa[DW-1 -: 2] == 2'b11) begin
                        m_lock = 0;
                        m_ptr = (m_gnt + 1) % N;
                    end
                end else begin
                    m_gnt = ap;
                    if (mode) m_lock = 1;
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            if (p == ap) begin
                s_stall[p] = 0;
                s_idx[p]++;
                if (s_idx[p] == s_len[p]) begin
                    s_idx[p] = 0;
                    s_pkt[p]++;
                    s_left[p]--;
                    s_len[p] = int'($urandom_range(s_lmax[p], s_lmin[p]));
                end
            end else if (ivalid[p]) begin
                s_stall[p]++;
                if (restart_en && s_stall[p] > 40) begin
                    s_stall[p] = 0;
                    s_idx[p] = 0;
                    s_pkt[p]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] held;
        int            acc2;
        int            tog3[3];
        int            ord3[$];
        logic [2:0]    a3;

        rst = 1'b1; mode = 1'b1; sel = '0; oready = 1'b1;
        idata = '0; ivalid = '0; ivch = '0;
        idata3 = '0; ivalid3 = '0; ivch3 = '0; mode3 = 1'b1; sel3 = '0;
        oready3 = 1'b1;
        vprob = 100; restart_en = 0; ilv_chk = 0; cur_port = 0;
        m_lock = 0; m_ov = 0; m_gnt = 0; m_ptr = 0; m_od = '0; m_ovch = '0;
        for (int p = 0; p < N; p++) begin
            s_idx[p] = 0; s_len[p] = 2; s_pkt[p] = 0; s_left[p] = 0;
            s_stall[p] = 0; s_lmin[p] = 2; s_lmax[p] = 2; deliv[p] = 0;
        end
        @(posedge clk);
        @(negedge clk);

        // Reset held with every port valid
        for (int p = 0; p < N; p++) src_set(p, 1, 3, 3);
        cycle();
        check("r1_odata", odata, '0);
        cycle();
        check("r1_odata2", odata, '0);
        src_off_all();
        rst = 1'b0;
        rst_pulse();

        // Static select streams port 1
        mode = 1'b0; sel = 2'd1;
        for (int p = 0; p < N; p++) deliv[p] = 0;
        src_set(1, 1, 22, 22);
        src_set(0, 1, 5, 5);
        run(30);
        check("t2_cnt1", deliv[1], 22);
        check("t2_cnt0", deliv[0], 0);
        src_off_all();
        mode = 1'b1;
        rst_pulse();

        // Round-robin fairness, all ports back-to-back
        head_order.delete();
        for (int p = 0; p < N; p++) src_set(p, 2, 3, 3);
        ilv_chk = 1;
        run(40);
        ilv_chk = 0;
        check("t3_nheads", head_order.size(), 8);
        for (int i = 0; i < 8 && i < head_order.size(); i++)
            check($sformatf("t3_ord%0d", i), head_order[i], i % 4);
        src_off_all();
        rst_pulse();

        // Backpressure mid-packet
        for (int p = 0; p < N; p++) deliv[p] = 0;
        src_set(0, 1, 12, 12);
        run(5);
        oready = 1'b0;
        held = m_od;
        repeat (5) begin
            cycle();
            check("t4_hold", odata, held);
            check("t4_ovalid", ovalid, 1);
        end
        oready = 1'b1;
        run(15);
        check("t4_cnt", deliv[0], 12);
        src_off_all();
        rst_pulse();

        // Reset in the middle of a port-2 packet
        src_set(1, 1, 3, 3);
        for (int i = 0; i < 20 && s_left[1] > 0; i++) cycle();
        run(2);
        src_set(2, 1, 6, 6);
        for (int i = 0; i < 20 && s_idx[2] < 3; i++) cycle();
        check("t5_pre", s_idx[2], 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_locked", locked, 0);
        check("t5_ovalid", ovalid, 0);
        acc2 = 0;
        repeat (8) begin
            cycle();
            acc2 += int'(dut_acc[2]);
        end
        check("t5_noacc", acc2, 0);
        head_order.delete();
        src_set(1, 1, 3, 3);
        src_set(3, 1, 3, 3);
        run(12);
        check("t5_first", head_order.size() > 0 ? head_order[0] : -1, 1);
        src_off_all();
        rst_pulse();

        // Randomized traffic with mode glitches and stray resets
        for (int p = 0; p < N; p++) src_set(p, 1000, 2, 6);
        vprob = 70;
        restart_en = 1;
        repeat (800) begin
            mode   = ($urandom_range(99) < 4) ? 1'b0 : 1'b1;
            sel    = PW'($urandom_range(N - 1));
            oready = ($urandom_range(99) < 75);
            rst    = ($urandom_range(999) < 5);
            cycle();
        end
        rst = 1'b0; mode = 1'b1; oready = 1'b1;
        restart_en = 0; vprob = 100;
        src_off_all();
        rst_pulse();

        // Three-port instance: grant must wrap 2 -> 0
        for (int p = 0; p < 3; p++) tog3[p] = 0;
        repeat (16) begin
            for (int p = 0; p < 3; p++) begin
                idata3[p*DW +: DW] = mkflit(p, 0, tog3[p], 2);
                ivch3[p*VW +: VW] = VW'(p);
            end
            ivalid3 = 3'b111;
            #1;
            check("t6_gnt_rng", gnt3 < 2'd3, 1);
            if (ovalid3 && odata3[DW-1 -: 2] == 2'b01)
                ord3.push_back(int'(odata3[DW-3 -: 8]));
            a3 = ivalid3 & iready3;
            @(posedge clk);
            for (int p = 0; p < 3; p++) if (a3[p]) tog3[p] = 1 - tog3[p];
            @(negedge clk);
        end
        ivalid3 = '0;
        check("t6_nheads", ord3.size() >= 6, 1);
        for (int i = 0; i < 6 && i < ord3.size(); i++)
            check($sformatf("t6_ord%0d", i), ord3[i], i % 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
